apple_timing_gen: RTL and testbench



---
 rtl/apple_timing_pkg.sv | 30 +++
 rtl/apple_phase_counter.sv | 64 ++++++
 rtl/apple_timing_gen.sv | 103 ++++++++++
 tb/tb_apple_timing_gen.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apple_timing_pkg.sv
// Shared defaults, width helpers and frame-length constants for the Apple IIe timing generator.
// Imported by apple_timing_gen and apple_phase_counter.
package apple_timing_pkg;

    localparam int DEF_HALF_CYCLE      = 7;
    localparam int DEF_STRETCH         = 2;
    localparam int DEF_Q3_HIGH         = 4;
    localparam int DEF_CYCLES_PER_LINE = 65;

    localparam int LINES_NTSC_STD = 262;
    localparam int LINES_PAL_STD  = 312;

    // A counter holding 0..n-1 never needs fewer than one bit.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int h_width(input int cycles_per_line);
        return width_of(cycles_per_line);
    endfunction

    function automatic int v_width(input int lines_ntsc, input int lines_pal);
        return width_of((lines_ntsc > lines_pal) ? lines_ntsc : lines_pal);
    endfunction

    function automatic int t_width(input int half_cycle, input int stretch);
        return width_of(half_cycle + stretch);
    endfunction

endpackage

// File: rtl/apple_phase_counter.sv
// PHI0 phase sequencer: tick counter t and phase bit p, including the stretched
// high phase of the last CPU cycle of each scan line.
module apple_phase_counter
    import apple_timing_pkg::*;
#(
    parameter int HALF_CYCLE = DEF_HALF_CYCLE,
    parameter int STRETCH    = DEF_STRETCH,
    parameter int Q3_HIGH    = DEF_Q3_HIGH,
    parameter int T_W        = t_width(DEF_HALF_CYCLE, DEF_STRETCH)
) (
    input  logic clk_14M,
    input  logic reset_n,
    input  logic run,
    input  logic last_cycle,
    output logic phase,
    output logic phase_end,
    output logic phi0,
    output logic q3,
    output logic phi0_rise,
    output logic phi0_fall
);

    // Last tick index of each phase kind; comparing against len-1 keeps the
    // constants inside T_W even when HALF_CYCLE+STRETCH is a power of two.
    localparam logic [T_W-1:0] T_LAST_NORM = T_W'(HALF_CYCLE - 1);
    localparam logic [T_W-1:0] T_LAST_LONG = T_W'(HALF_CYCLE + STRETCH - 1);
    localparam logic [T_W-1:0] T_Q3        = T_W'(Q3_HIGH);

    logic [T_W-1:0] t;
    logic           p;
    logic [T_W-1:0] t_last;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        t_last = T_LAST_NORM;
        if (p && last_cycle) begin
            t_last = T_LAST_LONG;
        end
    end

    assign phase_end = (t == t_last);

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
    always_ff @(posedge clk_14M) begin
        if (!reset_n) begin
            t <= '0;
            p <= 1'b0;
        end else if (run) begin
            if (phase_end) begin
                t <= '0;
                p <= ~p;
            end else begin
                t <= t + T_W'(1);
            end
        end
    end

    assign phase     = p;
    assign phi0      = run & p;
    assign q3        = run & (t < T_Q3);
    assign phi0_rise = run & p & (t == '0);
    assign phi0_fall = run & ~p & (t == '0);

endmodule

// File: rtl/apple_timing_gen.sv
// Apple IIe clock generator: 7M, PHI0, Q3 levels plus cycle/line/frame counters
// and strobes, all derived from the 14M master clock as enables.
module apple_timing_gen
    import apple_timing_pkg::*;
#(
    parameter int HALF_CYCLE      = DEF_HALF_CYCLE,
    parameter int STRETCH         = DEF_STRETCH,
    parameter int Q3_HIGH         = DEF_Q3_HIGH,
    parameter int CYCLES_PER_LINE = DEF_CYCLES_PER_LINE,
    parameter int LINES_NTSC      = LINES_NTSC_STD,
    parameter int LINES_PAL       = LINES_PAL_STD,
    localparam int H_W = h_width(CYCLES_PER_LINE),
    localparam int V_W = v_width(LINES_NTSC, LINES_PAL),
    localparam int T_W = t_width(HALF_CYCLE, STRETCH)
) (
    input  logic           clk_14M,
    input  logic           reset_n,
    input  logic           pal_sel,
    output logic           clk_7M,
    output logic           phi0,
    output logic           q3,
    output logic           phi0_rise,
    output logic           phi0_fall,
    output logic [H_W-1:0] h_count,
    output logic [V_W-1:0] v_count,
    output logic           line_start,
    output logic           frame_start,
    output logic           pal_active
);

    localparam logic [H_W-1:0] H_LAST      = H_W'(CYCLES_PER_LINE - 1);
    localparam logic [V_W-1:0] V_LAST_NTSC = V_W'(LINES_NTSC - 1);
    localparam logic [V_W-1:0] V_LAST_PAL  = V_W'(LINES_PAL - 1);

    logic           run;
    logic           c7;
    logic [H_W-1:0] h;
    logic [V_W-1:0] v;
    logic           pal_q;
    logic           phase;
    logic           phase_end;
    logic           last_cycle;
    logic [V_W-1:0] v_last;

    assign last_cycle = (h == H_LAST);
    // Frame length follows the mode latched at the previous wrap, not live pal_sel.
    assign v_last     = pal_q ? V_LAST_PAL : V_LAST_NTSC;

    apple_phase_counter #(
        .HALF_CYCLE (HALF_CYCLE),
        .STRETCH    (STRETCH),
        .Q3_HIGH    (Q3_HIGH),
        .T_W        (T_W)
    ) u_phase (
        .clk_14M    (clk_14M),
        .reset_n    (reset_n),
        .run        (run),
        .last_cycle (last_cycle),
        .phase      (phase),
        .phase_end  (phase_end),
        .phi0       (phi0),
        .q3         (q3),
        .phi0_rise  (phi0_rise),
        .phi0_fall  (phi0_fall)
    );

    // The release edge only sets run; counting starts on the edge after it.
    always_ff @(posedge clk_14M) begin
        if (!reset_n) begin
            run   <= 1'b0;
            c7    <= 1'b0;
            h     <= '0;
            v     <= '0;
            pal_q <= pal_sel;
        end else begin
            run <= 1'b1;
            if (run) begin
                c7 <= ~c7;
                if (phase_end && phase) begin
                    if (last_cycle) begin
                        h <= '0;
                        if (v == v_last) begin
                            v     <= '0;
                            pal_q <= pal_sel;
                        end else begin
                            v <= v + V_W'(1);
                        end
                    end else begin
                        h <= h + H_W'(1);
                    end
                end
            end
        end
    end

    assign clk_7M      = run & c7;
    assign h_count     = run ? h : '0;
    assign v_count     = run ? v : '0;
    assign line_start  = phi0_fall & (h == '0);
    assign frame_start = line_start & (v == '0);
    assign pal_active  = pal_q;

endmodule

// File: tb/tb_apple_timing_gen.sv
// Scoreboard bench for apple_timing_gen: expected gaps and duty counts are queued
// by the stimulus and consumed by a monitor as strobes appear.
module tb_apple_timing_gen;

    // Full CPU/line timing; frame lengths shortened to keep the run short.
    localparam int LN = 5;
    localparam int LP = 7;
    localparam int LINE_TICKS   = 912;
    localparam int FRAME_NTSC   = LN * LINE_TICKS;   // 4560
    localparam int FRAME_PAL    = LP * LINE_TICKS;   // 6384
    localparam int H_W = 7;
    localparam int V_W = 3;

    typedef struct {
        int   gap;
        int   vmax;
        logic pal;
    } frame_exp_t;

    typedef struct {
        int hi;
        int lo;
    } q3_exp_t;

    logic           clk_14M = 1'b0;
    logic           reset_n = 1'b0;
    logic           pal_sel = 1'b0;
    logic           clk_7M;
    logic           phi0;
    logic           q3;
    logic           phi0_rise;
    logic           phi0_fall;
    logic [H_W-1:0] h_count;
    logic [V_W-1:0] v_count;
    logic           line_start;
    logic           frame_start;
    logic           pal_active;

    int checks   = 0;
    int failures = 0;

    int         exp_rise[$];
    int         exp_line[$];
    q3_exp_t    exp_q3[$];
    frame_exp_t exp_frame[$];

    apple_timing_gen #(
        .LINES_NTSC (LN),
        .LINES_PAL  (LP)
    ) dut (
        .clk_14M     (clk_14M),
        .reset_n     (reset_n),
        .pal_sel     (pal_sel),
        .clk_7M      (clk_7M),
        .phi0        (phi0),
        .q3          (q3),
        .phi0_rise   (phi0_rise),
        .phi0_fall   (phi0_fall),
        .h_count     (h_count),
        .v_count     (v_count),
        .line_start  (line_start),
        .frame_start (frame_start),
        .pal_active  (pal_active)
    );

    always #5 clk_14M = ~clk_14M;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Expectations for the first line after a (re)start.
    task automatic push_line_expect();
        q3_exp_t q;
        for (int i = 0; i < 64; i++) exp_rise.push_back(14);
        exp_rise.push_back(16);
        for (int k = 0; k < 130; k++) begin
            q.hi = 4;
            q.lo = (k == 129) ? 5 : 3;
            exp_q3.push_back(q);
        end
    endtask

    task automatic push_frame(input int gap, input int vmax, input logic pal);
        frame_exp_t f;
        f.gap  = gap;
        f.vmax = vmax;
        f.pal  = pal;
        exp_frame.push_back(f);
    endtask

    task automatic check_idle(input string name);
        check(name, 32'({clk_7M, phi0, q3, phi0_rise, phi0_fall, line_start, frame_start}), 32'd0);
        check({name, " h/v"}, 32'({h_count, v_count}), 32'd0);
    endtask

    task automatic check_first_cycle(input string name);
        // frame_start, line_start, phi0_fall, q3 high; phi0, phi0_rise, clk_7M low
        check(name, 32'({frame_start, line_start, phi0_fall, q3, phi0, phi0_rise, clk_7M}), 32'b1111000);
        check({name, " h/v"}, 32'({h_count, v_count}), 32'd0);
    endtask

    task automatic wait_frames_drained(input int budget);
        int n = 0;
        while (exp_frame.size() != 0 && n < budget) begin
            @(negedge clk_14M);
            n++;
        end
        check("frame wait", 32'(exp_frame.size()), 32'd0);
    endtask

    task automatic wait_hv(input int h, input int v, input int budget);
        int n = 0;
        while (!(int'(h_count) == h && int'(v_count) == v) && n < budget) begin
            @(negedge clk_14M);
            n++;
        end
        check("wait v_count", 32'(v_count), 32'(v));
        check("wait h_count", 32'(h_count), 32'(h));
    endtask

    // Monitor: pops expectations as strobes occur.
    initial begin : monitor
        int      tick = 0;
        int      last_rise = 0, last_line = 0, last_frame = 0;
        bit      have_rise = 0, have_line = 0, have_frame = 0;
        bit      in_phase = 0, run_seen = 0;
        int      q3_hi = 0, q3_lo = 0, vmax = 0, c7_left = 0;
        logic    prev_c7 = 1'b0;
        q3_exp_t q;
        frame_exp_t f;
        forever begin
            @(negedge clk_14M);
            tick++;
            if (!reset_n) begin
                have_rise  = 0;
                have_line  = 0;
                have_frame = 0;
                in_phase   = 0;
                run_seen   = 0;
                c7_left    = 0;
            end else begin
                if (c7_left > 0) begin
                    check("clk_7M toggle", 32'(clk_7M), 32'(!prev_c7));
                    c7_left--;
                end
                prev_c7 = clk_7M;
                if (frame_start && !run_seen) begin
                    run_seen = 1;
                    c7_left  = 32;
                end

                if (phi0_rise) begin
                    if (have_rise && exp_rise.size() > 0)
                        check("phi0_rise gap", 32'(tick - last_rise), 32'(exp_rise.pop_front()));
                    have_rise = 1;
                    last_rise = tick;
                end

                if (phi0_rise || phi0_fall) begin
                    if (in_phase && exp_q3.size() > 0) begin
                        q = exp_q3.pop_front();
                        check("q3 high ticks", 32'(q3_hi), 32'(q.hi));
                        check("q3 low ticks", 32'(q3_lo), 32'(q.lo));
                    end
                    in_phase = 1;
                    q3_hi    = 0;
                    q3_lo    = 0;
                end
                if (in_phase) begin
                    if (q3) q3_hi++;
                    else    q3_lo++;
                end

                if (line_start) begin
                    if (have_line && exp_line.size() > 0)
                        check("line_start gap", 32'(tick - last_line), 32'(exp_line.pop_front()));
                    have_line = 1;
                    last_line = tick;
                end

                if (have_frame && int'(v_count) > vmax) vmax = int'(v_count);
                if (frame_start) begin
                    if (have_frame && exp_frame.size() > 0) begin
                        f = exp_frame.pop_front();
                        check("frame_start gap", 32'(tick - last_frame), 32'(f.gap));
                        check("v_count max", 32'(vmax), 32'(f.vmax));
                        check("pal_active at wrap", 32'(pal_active), 32'(f.pal));
                    end
                    have_frame = 1;
                    last_frame = tick;
                    vmax       = 0;
                end
            end
        end
    end

    // Stimulus
    initial begin : stimulus
        int n;
        push_line_expect();
        exp_line.push_back(LINE_TICKS);
        exp_line.push_back(LINE_TICKS);
        push_frame(FRAME_NTSC, LN - 1, 1'b0);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk_14M);
            check_idle("reset outputs");
            check("pal_active in reset", 32'(pal_active), 32'(pal_sel));
        end
        #1 reset_n = 1'b1;
        @(negedge clk_14M);
        check_first_cycle("first run cycle");

        wait_frames_drained(FRAME_NTSC + 100);
        wait_hv(0, 2, LINE_TICKS * 3);
        #1 pal_sel = 1'b1;
        push_frame(FRAME_NTSC, LN - 1, 1'b1);
        push_frame(FRAME_PAL, LP - 1, 1'b1);
        @(negedge clk_14M);
        check("pal_active mid-frame", 32'(pal_active), 32'd0);

        wait_frames_drained(FRAME_NTSC + FRAME_PAL + 200);
        wait_hv(30, 3, LINE_TICKS * 5);
        #1;
        pal_sel = 1'b0;
        reset_n = 1'b0;
        push_line_expect();
        exp_line.push_back(LINE_TICKS);
        push_frame(FRAME_NTSC, LN - 1, 1'b0);
        @(negedge clk_14M);
        check_idle("pulse reset outputs");
        check("pal_active after reset", 32'(pal_active), 32'd0);
        #1 reset_n = 1'b1;
        @(negedge clk_14M);
        check_first_cycle("restart first cycle");

        n = 0;
        while ((exp_frame.size() + exp_line.size() + exp_rise.size() + exp_q3.size()) != 0 && n < FRAME_NTSC + 200) begin
            @(negedge clk_14M);
            n++;
        end
        check("leftover frame exp", 32'(exp_frame.size()), 32'd0);
        check("leftover line exp", 32'(exp_line.size()), 32'd0);
        check("leftover rise exp", 32'(exp_rise.size()), 32'd0);
        check("leftover q3 exp", 32'(exp_q3.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
